multicycle_ctrl: RTL and testbench

Main control unit for the multicycle RV32I core, replacing the single-cycle decoder. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. A combinational ALU decoder and an immediate-select decoder drive the shared ALU, memory, instruction register and register file. It sits beside the multicycle datapath inside `top` and is driven only by `clk`, `reset`, `Zero` and instruction fields.

---
 rtl/riscv_ctrl_pkg.sv | 64 ++++++
 rtl/alu_decoder.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
//   Shared encodings for the multicycle RV32I control unit:
//   - the FSM state enum ctrl_state_t (11 states, 4 bits)
//   - opcode values
//   - ALUOp, ALUControl, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings
//   Optional feature macro used by importers: RV_BNE_EN (bne support).
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      JAL      = 4'd9,
      BEQ      = 4'd10
   } ctrl_state_t;

   // Opcodes (Instr[6:0])
   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // ALUOp: what the FSM asks of the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALUControl
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // ImmSrc
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // ResultSrc
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALUSrcA
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   // ALUSrcB
   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
//   Combinational ALU decoder. Turns the FSM's ALUOp plus instruction
//   fields into an ALUControl code. Unlisted funct3 values decode to add
//   so the output is never X.
//   Ports:
//     ALUOp      in  2  00 add, 01 sub, 10 decode from funct fields
//     funct3     in  3  Instr[14:12]
//     op5        in  1  Instr[5] (distinguishes R-type from I-ALU)
//     funct7b5   in  1  Instr[30]
//     ALUControl out 3  ALU operation
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] ALUControl
);

   always_comb begin
      ALUControl = ALU_ADD;
      case (ALUOp)
         ALUOP_ADD: ALUControl = ALU_ADD;
         ALUOP_SUB: ALUControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // Only R-type has a sub; addi with a negative immediate
               // sets Instr[30] but must still add.
               3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  ALUControl = ALU_SLT;
               3'b110:  ALUControl = ALU_OR;
               3'b111:  ALUControl = ALU_AND;
               default: ALUControl = ALU_ADD;
            endcase
         end
         default: ALUControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Main control unit of the multicycle RV32I core. A Moore FSM walks each
//   instruction through fetch/decode/execute/memory/writeback; outputs are
//   combinational from the state and instruction fields.
//   Optional feature: define RV_BNE_EN to make funct3=001 branches bne.
//   Ports:
//     clk        in  1  core clock, rising edge
//     reset      in  1  asynchronous active-high, forces FETCH
//     op         in  7  Instr[6:0]
//     funct3     in  3  Instr[14:12]
//     funct7b5   in  1  Instr[30]
//     Zero       in  1  ALU zero flag
//     PCWrite    out 1  PC enable
//     AdrSrc     out 1  memory address: 0 PC, 1 ALUOut
//     MemWrite   out 1  data memory write strobe
//     IRWrite    out 1  instruction/OldPC register enable
//     RegWrite   out 1  register file write enable
//     ResultSrc  out 2  00 ALUOut, 01 Data, 10 ALUResult
//     ALUSrcA    out 2  00 PC, 01 OldPC, 10 RD1
//     ALUSrcB    out 2  00 RD2, 01 ImmExt, 10 constant 4
//     ALUControl out 3  ALU operation
//     ImmSrc     out 2  00 I, 01 S, 10 B, 11 J
//     State      out 4  current FSM state (debug)
module multicycle_ctrl
   import riscv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic [3:0] State
);

   ctrl_state_t state, state_next;
   logic        pc_update, branch, branch_taken;
   logic        mem_write_s, ir_write_s, reg_write_s;
   logic [1:0]  alu_op;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   always_comb begin
      state_next = FETCH;
      case (state)
         FETCH:  state_next = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_RTYPE:     state_next = EXECUTER;
               OP_IALU:      state_next = EXECUTEI;
               OP_JAL:       state_next = JAL;
               OP_BRANCH:    state_next = BEQ;
               default:      state_next = FETCH;
            endcase
         end
         MEMADR:   state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  state_next = MEMWB;
         MEMWB:    state_next = FETCH;
         MEMWRITE: state_next = FETCH;
         EXECUTER: state_next = ALUWB;
         EXECUTEI: state_next = ALUWB;
         ALUWB:    state_next = FETCH;
         JAL:      state_next = ALUWB;
         BEQ:      state_next = FETCH;
         default:  state_next = FETCH;
      endcase
   end

   // Moore output decode
   always_comb begin
      pc_update   = 1'b0;
      branch      = 1'b0;
      AdrSrc      = 1'b0;
      mem_write_s = 1'b0;
      ir_write_s  = 1'b0;
      reg_write_s = 1'b0;
      ResultSrc   = RES_ALUOUT;
      ALUSrcA     = SRCA_PC;
      ALUSrcB     = SRCB_RD2;
      alu_op      = ALUOP_ADD;
      case (state)
         FETCH: begin
            ir_write_s = 1'b1;
            ALUSrcB    = SRCB_FOUR;
            ResultSrc  = RES_ALURESULT;
            pc_update  = 1'b1;
         end
         DECODE: begin
            // Precompute the branch target into ALUOut
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         MEMADR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
         end
         MEMREAD:  AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc   = RES_DATA;
            reg_write_s = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc      = 1'b1;
            mem_write_s = 1'b1;
         end
         EXECUTER: begin
            ALUSrcA = SRCA_RD1;
            alu_op  = ALUOP_FUNCT;
         end
         EXECUTEI: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
         end
         ALUWB:    reg_write_s = 1'b1;
         JAL: begin
            // PC <= target (from ALUOut); ALU computes OldPC+4 for rd
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            pc_update = 1'b1;
         end
         BEQ: begin
            ALUSrcA = SRCA_RD1;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef RV_BNE_EN
   assign branch_taken = Zero ^ funct3[0];
`else
   assign branch_taken = Zero;
`endif

   // Write strobes are held off for the whole time reset is high so an
   // abandoned instruction never leaks a partial write.
   assign PCWrite  = ~reset & (pc_update | (branch & branch_taken));
   assign IRWrite  = ~reset & ir_write_s;
   assign RegWrite = ~reset & reg_write_s;
   assign MemWrite = ~reset & mem_write_s;
   assign State    = state;

   always_comb begin
      case (op)
         OP_LW, OP_IALU: ImmSrc = IMM_I;
         OP_SW:          ImmSrc = IMM_S;
         OP_BRANCH:      ImmSrc = IMM_B;
         OP_JAL:         ImmSrc = IMM_J;
         default:        ImmSrc = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .ALUOp      (alu_op),
      .funct3     (funct3),
      .op5        (op[5]),
      .funct7b5   (funct7b5),
      .ALUControl (ALUControl)
   );

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
   import riscv_ctrl_pkg::*;

   logic       clk, reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, Zero;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] State;

   int n_cmp = 0;
   int n_bad = 0;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
      .ImmSrc(ImmSrc), .State(State)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Instruction class from the opcode: 0 lw, 1 sw, 2 R, 3 I-ALU, 4 jal, 5 branch, 6 other
   function automatic int op_class(input logic [6:0] o);
      case (o)
         7'b0000011: return 0;
         7'b0100011: return 1;
         7'b0110011: return 2;
         7'b0010011: return 3;
         7'b1101111: return 4;
         7'b1100011: return 5;
         default:    return 6;
      endcase
   endfunction

   // ALU operation an R/I instruction needs, from its mnemonic meaning
   function automatic logic [3:0] alu_for(input logic [31:0] instr);
      case (instr[14:12])
         3'd0:    return (instr[5] && instr[30]) ? 4'd1 : 4'd0; // sub only for R-type
         3'd2:    return 4'd5;  // slt
         3'd6:    return 4'd3;  // or
         3'd7:    return 4'd2;  // and
         default: return 4'd0;
      endcase
   endfunction

   // ---------------- driver + per-cycle checking ----------------
   // Called just after a rising edge with the DUT about to be in FETCH.
   // zmode: 0 Zero=0, 1 Zero=1, 2 random each cycle.
   task automatic run_instr(input logic [31:0] instr, input int zmode, input string tag);
      int          cls, last;
      ctrl_state_t exp_q[$];
      logic [3:0]  got[11];
      logic [3:0]  expv[11];
      string       nm[11];
      bit          taken;
      op       = instr[6:0];
      funct3   = instr[14:12];
      funct7b5 = instr[30];
      cls = op_class(instr[6:0]);
      exp_q = {FETCH, DECODE};
      case (cls)
         0: exp_q = {exp_q, MEMADR, MEMREAD, MEMWB};
         1: exp_q = {exp_q, MEMADR, MEMWRITE};
         2: exp_q = {exp_q, EXECUTER, ALUWB};
         3: exp_q = {exp_q, EXECUTEI, ALUWB};
         4: exp_q = {exp_q, JAL, ALUWB};
         5: exp_q = {exp_q, BEQ};
         default: ;
      endcase
      last = exp_q.size() - 1;
      nm = '{"state", "pcwrite", "irwrite", "regwrite", "memwrite", "adrsrc",
             "immsrc", "alucontrol", "resultsrc", "alusrca", "alusrcb"};
      for (int k = 0; k <= last; k++) begin
         if (zmode == 2) Zero = 1'($urandom_range(0, 1));
         else            Zero = (zmode == 1);
         @(negedge clk);
`ifdef RV_BNE_EN
         taken = Zero ^ instr[12];
`else
         taken = Zero;
`endif
         expv[0] = 4'(exp_q[k]);
         expv[1] = 4'((k == 0) || (k == 2 && cls == 4) || (k == 2 && cls == 5 && taken));
         expv[2] = 4'(k == 0);
         expv[3] = 4'(k == last && (cls == 0 || cls == 2 || cls == 3 || cls == 4));
         expv[4] = 4'(k == last && cls == 1);
         expv[5] = 4'(k == 3 && (cls == 0 || cls == 1));
         expv[6] = (cls == 1) ? 4'd1 : (cls == 5) ? 4'd2 : (cls == 4) ? 4'd3 : 4'd0;
         if (k == 2 && cls == 5)                    expv[7] = 4'd1;
         else if (k == 2 && (cls == 2 || cls == 3)) expv[7] = alu_for(instr);
         else                                       expv[7] = 4'd0;
         expv[8] = (k == 0) ? 4'd2 : (k == 4 && cls == 0) ? 4'd1 : 4'd0;
         // ALU operand selection: fetch PC+4, decode OldPC+imm, then per class
         if (k == 0)      begin expv[9] = 4'd0; expv[10] = 4'd2; end
         else if (k == 1) begin expv[9] = 4'd1; expv[10] = 4'd1; end
         else if (k == 2) begin
            case (cls)
               0, 1, 3: begin expv[9] = 4'd2; expv[10] = 4'd1; end
               4:       begin expv[9] = 4'd1; expv[10] = 4'd2; end
               default: begin expv[9] = 4'd2; expv[10] = 4'd0; end
            endcase
         end
         else begin expv[9] = 4'd0; expv[10] = 4'd0; end
         got = '{State, 4'(PCWrite), 4'(IRWrite), 4'(RegWrite), 4'(MemWrite),
                 4'(AdrSrc), 4'(ImmSrc), 4'(ALUControl), 4'(ResultSrc),
                 4'(ALUSrcA), 4'(ALUSrcB)};
         for (int i = 0; i < 11; i++) begin
            n_cmp++;
            if (got[i] !== expv[i]) begin
               n_bad++;
               $display("FAIL %s cycle%0d %s: got %0h expected %0h (instr %08h Zero %0b)",
                        tag, k + 1, nm[i], got[i], expv[i], instr, Zero);
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      op = 7'h7F; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (State !== 4'd0)   begin n_bad++; $display("FAIL reset state: got %0d expected 0", State); end
      n_cmp++; if (PCWrite !== 1'b0) begin n_bad++; $display("FAIL reset pcwrite: got %0b expected 0", PCWrite); end
      n_cmp++; if (IRWrite !== 1'b0) begin n_bad++; $display("FAIL reset irwrite: got %0b expected 0", IRWrite); end
      n_cmp++; if ({RegWrite, MemWrite} !== 2'b00) begin n_bad++; $display("FAIL reset strobes: got %0b%0b expected 00", RegWrite, MemWrite); end
      n_cmp++; if ({ResultSrc, ALUSrcA, ALUSrcB} !== 6'b10_00_10) begin n_bad++; $display("FAIL reset fetch muxes: got %06b expected 100010", {ResultSrc, ALUSrcA, ALUSrcB}); end
      @(posedge clk);
      #1 reset = 1'b0;
      run_instr(32'h00402283, 0, "post_reset_lw");
   endtask

   task automatic test_lw_sw();
      run_instr(32'h00402283, 2, "lw");
      run_instr(32'h00502423, 2, "sw");
   endtask

   task automatic test_rtype();
      run_instr(32'h402081B3, 2, "sub");
      run_instr(32'h0020E1B3, 2, "or");
      run_instr(32'hFFF08093, 2, "addi_neg");
   endtask

   task automatic test_branch();
      run_instr(32'h00208463, 1, "beq_taken");
      run_instr(32'h00208463, 0, "beq_not_taken");
      run_instr(32'h00209463, 1, "bne_zero1");
      run_instr(32'h00209463, 0, "bne_zero0");
      run_instr(32'h008000EF, 2, "jal");
   endtask

   task automatic test_unknown();
      run_instr(32'h0000007F, 2, "op7f");
   endtask

   task automatic test_reset_mid();
      op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      n_cmp++; if (State !== 4'(MEMREAD)) begin n_bad++; $display("FAIL midreset pre-state: got %0d expected %0d", State, MEMREAD); end
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (State !== 4'd0) begin n_bad++; $display("FAIL midreset async state: got %0d expected 0", State); end
      n_cmp++; if ({PCWrite, RegWrite, MemWrite, IRWrite} !== 4'b0) begin n_bad++; $display("FAIL midreset strobes: got %04b expected 0000", {PCWrite, RegWrite, MemWrite, IRWrite}); end
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (RegWrite !== 1'b0 || State !== 4'd0) begin n_bad++; $display("FAIL midreset held: got regwrite %0b state %0d expected 0/0", RegWrite, State); end
      @(posedge clk);
      #1 reset = 1'b0;
      run_instr(32'h402081B3, 2, "after_midreset");
   endtask

   task automatic test_back_to_back();
      logic [31:0] instr;
      logic [6:0]  opc[6];
      int          c;
      opc = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
      for (int n = 0; n < 200; n++) begin
         instr = $urandom();
         c = $urandom_range(0, 6);
         if (c < 6) instr[6:0] = opc[c];
         else while (op_class(instr[6:0]) != 6) instr[6:0] = 7'($urandom());
         run_instr(instr, 2, "random");
      end
   endtask

   initial begin
      test_reset();
      test_lw_sw();
      test_rtype();
      test_branch();
      test_unknown();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
